mem_port_arbiter: RTL

- Shares the single unified instruction/data memory port (word-addressed by adr[31:2], combinational read, write on clk edge) between two requesters.
- Requester 0 is the multicycle core's memory interface; requester 1 is a loader/debug master that fills or inspects memory.
- Round-robin arbitration, an optional bus lock for multi-word sequences, and a registered read-return path.
- Sits between the requesters and the memory in top-level integration.

---
 rtl/arb_pkg.sv | 5 +
 rtl/arb_rr_pick.sv | 19 +
 rtl/mem_port_arbiter.sv | 88 ++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// arb_pkg: shared types for mem_port_arbiter
package arb_pkg;
    localparam int ARB_N = 2;
    typedef enum logic [1:0] {OPEN = 2'd0, LOCK0 = 2'd1, LOCK1 = 2'd2} arb_state_t;
endpackage

// File: rtl/arb_rr_pick.sv
// arb_rr_pick: combinational 2-way round-robin picker honouring lock ownership
module arb_rr_pick
    import arb_pkg::*;
(
    input  logic [ARB_N-1:0] req,
    input  logic             last,
    input  arb_state_t       state,
    output logic [ARB_N-1:0] gnt,
    output logic             idx
);
    logic both;
    always_comb begin
        both = &req;
        idx = state == LOCK1 ? 1'b1 : state == LOCK0 ? 1'b0 : both ? ~last : req[1];
        gnt = state == LOCK0 ? {1'b0, req[0]} :
              state == LOCK1 ? {req[1], 1'b0} :
              both ? (last ? 2'b01 : 2'b10) : req;
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one memory port with bus lock and registered read return
// ARB_PERF_CNT_EN adds saturating grant/wait counters (gcnt0, gcnt1, wcnt1).
module mem_port_arbiter
    import arb_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
`ifdef ARB_PERF_CNT_EN
    , parameter int CNTW = 16
`endif
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] adr0,
    input  logic [AW-1:0] adr1,
    input  logic [DW-1:0] wd0,
    input  logic [DW-1:0] wd1,
    input  logic          lock0,
    input  logic          lock1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata,
    output logic          mem_we,
    output logic [AW-1:0] mem_adr,
    output logic [DW-1:0] mem_wd,
    input  logic [DW-1:0] mem_rd
`ifdef ARB_PERF_CNT_EN
    , output logic [CNTW-1:0] gcnt0
    , output logic [CNTW-1:0] gcnt1
    , output logic [CNTW-1:0] wcnt1
`endif
);
    arb_state_t state, state_nx, eff;
    logic       last, idx, lk;
    logic [1:0] g;
    // an idle owner that drops its lock frees the bus within the same cycle
    always_comb eff = (state == LOCK0 && !req0 && !lock0) || (state == LOCK1 && !req1 && !lock1) ? OPEN : state;
    arb_rr_pick u_pick (
        .req   ({req1, req0} & {2{~reset}}),
        .last  (last),
        .state (eff),
        .gnt   (g),
        .idx   (idx)
    );
    always_comb begin
        gnt0 = g[0];
        gnt1 = g[1];
        lk = idx ? lock1 : lock0;
        state_nx = |g ? (lk ? (idx ? LOCK1 : LOCK0) : OPEN) : eff;
        mem_we = (gnt0 & we0) | (gnt1 & we1);
        mem_adr = gnt0 ? adr0 : gnt1 ? adr1 : '0;
        mem_wd = gnt0 ? wd0 : gnt1 ? wd1 : '0;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= OPEN;
            last <= 1'b1;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            rdata <= '0;
        end else begin
            state <= state_nx;
            if (|g) last <= idx;
            rvalid0 <= gnt0 & ~we0;
            rvalid1 <= gnt1 & ~we1;
            if ((gnt0 & ~we0) | (gnt1 & ~we1)) rdata <= mem_rd;
        end
    end
`ifdef ARB_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gcnt0 <= '0;
            gcnt1 <= '0;
            wcnt1 <= '0;
        end else begin
            if (gnt0 && !(&gcnt0)) gcnt0 <= gcnt0 + 1'b1;
            if (gnt1 && !(&gcnt1)) gcnt1 <= gcnt1 + 1'b1;
            if (req1 && !gnt1 && !(&wcnt1)) wcnt1 <= wcnt1 + 1'b1;
        end
    end
`endif
endmodule
